// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data RAM between the CPU memory port and the
// decryption accelerator, and decodes the switch / LED memory-mapped I/O.
// The CPU normally wins the RAM. A starvation counter forces an accelerator
// grant after STARVE_LIMIT consecutive CPU wins against a pending request.
// Optional feature macro: DMEM_ARB_LED_READBACK_EN. When it is defined, a CPU
// read of IO_LED_ADDR returns {16'b0, led_out}. When it is undefined, that
// read is a null access and returns 0.
module dmem_arbiter #(
    parameter int          STARVE_LIMIT = 4,
    parameter logic [31:0] IO_SW_ADDR   = 32'd4096,
    parameter logic [31:0] IO_LED_ADDR  = 32'd4097
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic        cpu_wren,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        acc_req,
    input  logic        acc_wren,
    input  logic [11:0] acc_addr,
    input  logic [31:0] acc_wdata,
    output logic        acc_gnt,
    output logic        acc_rvalid,
    output logic [31:0] acc_rdata,
    output logic        ram_wEn,
    output logic [11:0] ram_addr,
    output logic [31:0] ram_dataIn,
    input  logic [31:0] ram_dataOut,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out
);
    localparam logic [31:0]      RAM_WORDS = 32'd4096;
    localparam int               CNT_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STARVE_LIMIT);

    logic             cpu_ram;
    logic             cpu_sw;
    logic             cpu_led;
    logic             cpu_led_rd;
    logic             cpu_rd_null;
    logic             force_gnt;
    logic [CNT_W-1:0] starve_cnt;

    // Read-source flags, one cycle behind the accepted request.
    logic             rd_acc_p1;
    logic             rd_cpu_ram_p1;
    logic             rd_sw_p1;
    logic             rd_led_p1;
    logic             rd_null_p1;

    // Switch synchronizer stages.
    logic [15:0]      sw_s1;
    logic [15:0]      sw_q;

    // The upper half of the LED write data has no destination.
    logic             unused_wdata_hi;
    assign unused_wdata_hi = ^cpu_wdata[31:16];

    // Address decode and priority arbitration between CPU and accelerator.
    always_comb begin
        cpu_ram = cpu_en && (cpu_addr < RAM_WORDS);
        cpu_sw  = cpu_en && !cpu_wren && (cpu_addr == IO_SW_ADDR);
        cpu_led = cpu_en &&  cpu_wren && (cpu_addr == IO_LED_ADDR);
`ifdef DMEM_ARB_LED_READBACK_EN
        cpu_led_rd = cpu_en && !cpu_wren && (cpu_addr == IO_LED_ADDR);
`else
        cpu_led_rd = 1'b0;
`endif
        // Any other CPU read falls through to the null source and returns 0.
        cpu_rd_null = cpu_en && !cpu_wren && !cpu_ram && !cpu_sw && !cpu_led_rd;
        force_gnt   = acc_req && (starve_cnt == CNT_MAX);
        acc_gnt     = acc_req && (!cpu_ram || force_gnt);
        cpu_stall   = cpu_ram && acc_gnt;
    end

    // RAM port mux: the granted accelerator first, then a CPU RAM access, else idle.
    always_comb begin
        ram_wEn    = 1'b0;
        ram_addr   = 12'h000;
        ram_dataIn = 32'h0000_0000;
        if (acc_gnt) begin
            ram_wEn    = acc_wren;
            ram_addr   = acc_addr;
            ram_dataIn = acc_wdata;
        end else if (cpu_ram) begin
            ram_wEn    = cpu_wren;
            ram_addr   = cpu_addr[11:0];
            ram_dataIn = cpu_wdata;
        end
    end

    // Count consecutive CPU wins against a waiting accelerator, saturating at the limit.
    always_ff @(posedge clock) begin
        if (reset || acc_gnt || !acc_req) begin
            starve_cnt <= '0;
        end else if (cpu_ram && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Two-flop synchronizer for the asynchronous board switches.
    always_ff @(posedge clock) begin
        if (reset) begin
            sw_s1 <= 16'h0000;
            sw_q  <= 16'h0000;
        end else begin
            sw_s1 <= sw_in;
            sw_q  <= sw_s1;
        end
    end

    // LED register is loaded by a CPU write to the LED address.
    always_ff @(posedge clock) begin
        if (reset) begin
            led_out <= 16'h0000;
        end else if (cpu_led) begin
            led_out <= cpu_wdata[15:0];
        end
    end

    // Stage p1: record where each accepted read has to return from.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_acc_p1     <= 1'b0;
            rd_cpu_ram_p1 <= 1'b0;
            rd_sw_p1      <= 1'b0;
            rd_led_p1     <= 1'b0;
            rd_null_p1    <= 1'b0;
        end else begin
            rd_acc_p1     <= acc_gnt && !acc_wren;
            rd_cpu_ram_p1 <= cpu_ram && !cpu_wren && !acc_gnt;
            rd_sw_p1      <= cpu_sw;
            rd_led_p1     <= cpu_led_rd;
            rd_null_p1    <= cpu_rd_null;
        end
    end

    // Stage p2: register the returned read data; cpu_rdata holds when no CPU read is returning.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_rvalid <= 1'b0;
            acc_rdata  <= 32'h0000_0000;
            cpu_rdata  <= 32'h0000_0000;
        end else begin
            acc_rvalid <= rd_acc_p1;
            if (rd_acc_p1) begin
                acc_rdata <= ram_dataOut;
            end
            if (rd_cpu_ram_p1) begin
                cpu_rdata <= ram_dataOut;
            end else if (rd_sw_p1) begin
                cpu_rdata <= {16'h0000, sw_q};
            end else if (rd_led_p1) begin
                cpu_rdata <= {16'h0000, led_out};
            end else if (rd_null_p1) begin
                cpu_rdata <= 32'h0000_0000;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Scoreboard bench for dmem_arbiter. The stimulus process drives one request
// per cycle and works out the expected arbitration from the behavioural rules
// (CPU priority, forced grant after STARVE_LIMIT CPU wins, I/O decode). It
// pushes the expected read data, tagged with the cycle it must appear, into
// queues. A separate monitor pops those queues and compares them on the
// falling edge.
module tb_dmem_arbiter;
    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_en = 1'b0;
    logic        cpu_wren = 1'b0;
    logic [31:0] cpu_addr = 32'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        acc_req = 1'b0;
    logic        acc_wren = 1'b0;
    logic [11:0] acc_addr = 12'h0;
    logic [31:0] acc_wdata = 32'h0;
    logic        acc_gnt;
    logic        acc_rvalid;
    logic [31:0] acc_rdata;
    logic        ram_wEn;
    logic [11:0] ram_addr;
    logic [31:0] ram_dataIn;
    logic [31:0] ram_dataOut;
    logic [15:0] sw_in = 16'h0;
    logic [15:0] led_out;

    always #5 clock = ~clock;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .cpu_en(cpu_en), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .acc_req(acc_req), .acc_wren(acc_wren), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
        .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata),
        .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut),
        .sw_in(sw_in), .led_out(led_out)
    );

    // Synchronous single-port RAM with one cycle of read latency.
    logic [31:0] ram_mem [0:4095];
    always @(posedge clock) begin
        if (ram_wEn) ram_mem[ram_addr] <= ram_dataIn;
        ram_dataOut <= ram_mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        acc_q[$];
    exp_t        cpu_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    // Reference state
    logic [31:0] ref_mem [0:4095];
    logic [15:0] exp_led = 16'h0;
    int          starve = 0;
    int          sw_age = 0;
    logic        rst_next = 1'b1;
    logic [15:0] cur_sw = 16'h0;
    logic [31:0] exp_cpu = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of requests and predict the DUT response from the rules.
    task automatic step(input logic en, input logic wren, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic areq, input logic awren,
                        input logic [11:0] aaddr, input logic [31:0] awdata,
                        input logic [15:0] sw, output logic gnt_o, output logic stall_o);
        logic r_ram, r_sw, r_ledw, r_ledr, forced, e_gnt, e_stall, e_wen;
        exp_t e;
        @(posedge clock);
        #1;
        if (sw != sw_in) sw_age = 0; else sw_age++;
        reset = rst_next;
        cpu_en = en; cpu_wren = wren; cpu_addr = addr; cpu_wdata = wdata;
        acc_req = areq; acc_wren = awren; acc_addr = aaddr; acc_wdata = awdata;
        sw_in = sw;
        #1;
        gnt_o = acc_gnt;
        stall_o = cpu_stall;
        if (reset) begin
            starve = 0;
            exp_led = 16'h0;
            sw_age = 0;
            return;
        end
        check("led_out", 32'(led_out), 32'(exp_led));
        r_ram  = en && (addr < 32'd4096);
        r_sw   = en && !wren && (addr == 32'd4096);
        r_ledw = en && wren && (addr == 32'd4097);
`ifdef DMEM_ARB_LED_READBACK_EN
        r_ledr = en && !wren && (addr == 32'd4097);
`else
        r_ledr = 1'b0;
`endif
        forced  = areq && (starve >= LIMIT);
        e_gnt   = areq && (!r_ram || forced);
        e_stall = r_ram && e_gnt;
        e_wen   = e_gnt ? awren : (r_ram && wren);
        check("acc_gnt", 32'(acc_gnt), 32'(e_gnt));
        check("cpu_stall", 32'(cpu_stall), 32'(e_stall));
        check("ram_wEn", 32'(ram_wEn), 32'(e_wen));
        if (e_gnt) check("ram_addr_acc", 32'(ram_addr), 32'(aaddr));
        if (e_gnt && !awren) begin
            e.due = cyc + 2;
            e.data = ref_mem[aaddr];
            acc_q.push_back(e);
        end
        if (en && !wren && !e_stall) begin
            e.due = cyc + 2;
            if (r_ram)       e.data = ref_mem[addr[11:0]];
            else if (r_sw)   e.data = {16'h0, sw};
            else if (r_ledr) e.data = {16'h0, exp_led};
            else             e.data = 32'h0;
            cpu_q.push_back(e);
        end
        if (e_gnt && awren) ref_mem[aaddr] = awdata;
        if (r_ram && wren && !e_stall) ref_mem[addr[11:0]] = wdata;
        if (r_ledw) exp_led = wdata[15:0];
        if (!areq || e_gnt) starve = 0;
        else if (starve < LIMIT) starve++;
    endtask

    task automatic idle(output logic g, output logic s);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, cur_sw, g, s);
    endtask

    // Monitor: compare the returned read data against the scoreboard.
    initial begin : monitor
        logic r;
        exp_t e;
        forever begin
            @(posedge clock);
            r = reset;
            @(negedge clock);
            if (r) begin
                acc_q.delete();
                cpu_q.delete();
                exp_cpu = 32'h0;
                check("rst_acc_rvalid", 32'(acc_rvalid), 32'h0);
                check("rst_acc_rdata", acc_rdata, 32'h0);
                check("rst_cpu_rdata", cpu_rdata, 32'h0);
                check("rst_led_out", 32'(led_out), 32'h0);
            end else begin
                while (acc_q.size() > 0 && acc_q[0].due < cyc) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL acc_rvalid_late: no rvalid by cycle %0d, required at %0d", cyc, acc_q[0].due);
                    void'(acc_q.pop_front());
                end
                if (acc_q.size() > 0 && acc_q[0].due == cyc) begin
                    e = acc_q.pop_front();
                    check("acc_rvalid", 32'(acc_rvalid), 32'h1);
                    check("acc_rdata", acc_rdata, e.data);
                end else begin
                    check("acc_rvalid_idle", 32'(acc_rvalid), 32'h0);
                end
                if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
                    e = cpu_q.pop_front();
                    exp_cpu = e.data;
                end
                check("cpu_rdata", cpu_rdata, exp_cpu);
            end
        end
    end

    initial begin : stimulus
        logic g, s;
        logic c_en, c_wr, a_rq, a_wr;
        logic [31:0] c_ad, c_wd, a_wd, exp_rb;
        logic [11:0] a_ad;
        logic [15:0] nsw;
        int nage, sel;

        // Reset, then release
        rst_next = 1'b1;
        repeat (3) idle(g, s);
        rst_next = 1'b0;
        idle(g, s);
        check("rel_led_out", 32'(led_out), 32'h0);
        check("rel_acc_rvalid", 32'(acc_rvalid), 32'h0);
        check("rel_cpu_stall", 32'(cpu_stall), 32'h0);

        // Switch read after synchronization
        cur_sw = 16'hA5A5;
        repeat (3) idle(g, s);
        step(1'b1, 1'b0, 32'd4096, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, cur_sw, g, s);
        idle(g, s);
        idle(g, s);
        check("sw_read", cpu_rdata, 32'h0000A5A5);

        // Preload RAM words 0..15 through the accelerator
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 12'(i), $urandom(), cur_sw, g, s);

        // Accelerator write then read-back
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 12'h010, 32'hDEADBEEF, cur_sw, g, s);
        check("acc_wr_gnt", 32'(g), 32'h1);
        check("acc_wr_wen", 32'(ram_wEn), 32'h1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 12'h010, 32'h0, cur_sw, g, s);
        idle(g, s);
        idle(g, s);
        check("acc_rd_valid", 32'(acc_rvalid), 32'h1);
        check("acc_rd_data", acc_rdata, 32'hDEADBEEF);

        // Starvation: CPU reads every cycle, accelerator always requesting
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b0, 32'd5, 32'h0, 1'b1, 1'b0, 12'h006, 32'h0, cur_sw, g, s);
            check("starve_stall", 32'(s), 32'((i % 5) == 4));
            check("starve_gnt", 32'(g), 32'((i % 5) == 4));
        end
        idle(g, s);

        // LED write concurrent with accelerator RAM write
        step(1'b1, 1'b1, 32'd4097, 32'h00011234, 1'b1, 1'b1, 12'h003, 32'h13579BDF, cur_sw, g, s);
        check("led_wr_stall", 32'(s), 32'h0);
        check("led_wr_acc_gnt", 32'(g), 32'h1);
        idle(g, s);
        check("led_set", 32'(led_out), 32'h1234);

        // LED read-back and a null write
        step(1'b1, 1'b0, 32'd4097, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, cur_sw, g, s);
        idle(g, s);
        idle(g, s);
`ifdef DMEM_ARB_LED_READBACK_EN
        exp_rb = 32'h00001234;
`else
        exp_rb = 32'h0;
`endif
        check("led_readback", cpu_rdata, exp_rb);
        step(1'b1, 1'b1, 32'd5000, 32'h0000FFFF, 1'b0, 1'b0, 12'h0, 32'h0, cur_sw, g, s);
        check("null_wr_wen", 32'(ram_wEn), 32'h0);
        idle(g, s);
        check("null_wr_led", 32'(led_out), 32'h1234);

        // Randomized traffic; stalled / ungranted requests are held
        c_en = 1'b0; c_wr = 1'b0; c_ad = 32'h0; c_wd = 32'h0;
        a_rq = 1'b0; a_wr = 1'b0; a_ad = 12'h0; a_wd = 32'h0;
        s = 1'b0; g = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!(c_en && s)) begin
                c_en = ($urandom_range(3) != 0);
                c_wr = 1'($urandom_range(1));
                c_wd = $urandom();
                sel = int'($urandom_range(7));
                if (sel < 5)       c_ad = 32'($urandom_range(15));
                else if (sel == 5) c_ad = 32'd4096;
                else if (sel == 6) c_ad = 32'd4097;
                else               c_ad = 32'd5000 + 32'($urandom_range(100000));
            end
            if (!(a_rq && !g)) begin
                a_rq = 1'($urandom_range(1));
                a_wr = 1'($urandom_range(1));
                a_ad = 12'($urandom_range(15));
                a_wd = $urandom();
            end
            nsw  = ($urandom_range(15) == 0) ? 16'($urandom()) : cur_sw;
            nage = (nsw != cur_sw) ? 0 : sw_age + 1;
            if (c_en && !c_wr && c_ad == 32'd4096 && nage < 3) c_ad = 32'd7;
            cur_sw = nsw;
            step(c_en, c_wr, c_ad, c_wd, a_rq, a_wr, a_ad, a_wd, cur_sw, g, s);
        end
        repeat (3) idle(g, s);

        // Reset arriving the cycle after a granted accelerator read
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 12'h002, 32'h0, cur_sw, g, s);
        check("rst_rd_gnt", 32'(g), 32'h1);
        rst_next = 1'b1;
        idle(g, s);
        idle(g, s);
        rst_next = 1'b0;
        idle(g, s);
        idle(g, s);
        check("post_rst_rvalid", 32'(acc_rvalid), 32'h0);
        check("post_rst_led", 32'(led_out), 32'h0);

        repeat (4) idle(g, s);
        check("acc_q_drained", 32'(acc_q.size()), 32'h0);
        check("cpu_q_drained", 32'(cpu_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
